// File: rtl/snake_pkg.sv
// Shared snake-game definitions: grid defaults, direction encodings and cell helpers.
// Used by both the movement/collision stage and the matrix scanner.
package snake_pkg;

    localparam int unsigned GRID_W  = 9;
    localparam int unsigned GRID_H  = 10;
    localparam int unsigned COORD_W = 4;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_e;

    typedef enum logic {
        ScanBlank = 1'b0,
        ScanDrive = 1'b1
    } scan_state_e;

    function automatic int unsigned cell_index(input logic [COORD_W-1:0] x,
                                               input logic [COORD_W-1:0] y,
                                               input int unsigned        w = GRID_W);
        return 32'(y) * w + 32'(x);
    endfunction

    function automatic logic in_grid(input logic [COORD_W-1:0] x,
                                     input logic [COORD_W-1:0] y,
                                     input int unsigned        w = GRID_W,
                                     input int unsigned        h = GRID_H);
        return (32'(x) < w) && (32'(y) < h);
    endfunction

endpackage

// File: rtl/snake_scan_timer.sv
// Row-scan sequencer: dwell/blank counters, row and frame counters, frame-boundary ready strobe.
// Exposes next-state values so the top can register pixel data on the same edge as the row drive.
module snake_scan_timer #(
    parameter int unsigned GRID_H       = 10,
    parameter int unsigned DWELL_CYCLES = 1000,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned FLASH_FRAMES = 30
) (
    input  logic       Game_Clk,
    input  logic       i_Rst_L,
    output logic       o_Scan_Nxt,
    output logic [3:0] o_Row_Nxt,
    output logic       o_Phase_Nxt,
    output logic       o_Frame_Ready
);
    import snake_pkg::*;

    localparam int unsigned CntMax = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned FrmN   = 2 * FLASH_FRAMES;
    localparam int unsigned FrmW   = $clog2(FrmN + 1);

    scan_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      row_q, row_d;
    logic [FrmW-1:0] frame_q, frame_d;
    logic            started_q, started_d;
    logic            ready_q, ready_d;

    // row_q holds the row being driven, or during blank the row to drive next.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CntW'(1);
        row_d     = row_q;
        frame_d   = frame_q;
        started_d = started_q;
        unique case (state_q)
            ScanBlank: begin
                if (cnt_q == CntW'(BLANK_CYCLES - 1)) begin
                    state_d   = ScanDrive;
                    cnt_d     = '0;
                    started_d = 1'b1;
                end
            end
            ScanDrive: begin
                if (cnt_q == CntW'(DWELL_CYCLES - 1)) begin
                    state_d = ScanBlank;
                    cnt_d   = '0;
                    if (row_q == 4'(GRID_H - 1)) begin
                        row_d   = '0;
                        frame_d = (frame_q == FrmW'(FrmN - 1)) ? '0 : frame_q + FrmW'(1);
                    end else begin
                        row_d = row_q + 4'd1;
                    end
                end
            end
            default: ;
        endcase
        // The blank that follows reset is not a frame boundary.
        ready_d = (state_d == ScanBlank) && (cnt_d == CntW'(BLANK_CYCLES - 1)) &&
                  (row_d == 4'd0) && started_d;
    end

    always_ff @(posedge Game_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= ScanBlank;
            cnt_q     <= '0;
            row_q     <= '0;
            frame_q   <= '0;
            started_q <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            row_q     <= row_d;
            frame_q   <= frame_d;
            started_q <= started_d;
            ready_q   <= ready_d;
        end
    end

    assign o_Scan_Nxt    = (state_d == ScanDrive);
    assign o_Row_Nxt     = row_d;
    assign o_Phase_Nxt   = (frame_d >= FrmW'(FLASH_FRAMES));
    assign o_Frame_Ready = ready_q;

endmodule

// File: rtl/snake_matrix_scanner.sv
// Double-buffered snake display scanner driving a multiplexed LED matrix row by row.
// Define SNAKE_FOOD_BLINK_EN to blink the food pixel with the collision flash period.
module snake_matrix_scanner #(
    parameter int unsigned GRID_W       = snake_pkg::GRID_W,
    parameter int unsigned GRID_H       = snake_pkg::GRID_H,
    parameter int unsigned DWELL_CYCLES = 1000,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned FLASH_FRAMES = 30
) (
    input  logic                     Game_Clk,
    input  logic                     i_Rst_L,
    input  logic                     i_Frame_Valid,
    output logic                     o_Frame_Ready,
    input  logic [GRID_W*GRID_H-1:0] i_SnakeBody,
    input  logic [3:0]               i_Head_X,
    input  logic [3:0]               i_Head_Y,
    input  logic [3:0]               i_Food_X,
    input  logic [3:0]               i_Food_Y,
    input  logic                     i_Collision,
    output logic [GRID_H-1:0]        o_Row_Sel,
    output logic [GRID_W-1:0]        o_Col_Body,
    output logic [GRID_W-1:0]        o_Col_Head,
    output logic [GRID_W-1:0]        o_Col_Food
);
    import snake_pkg::*;

    localparam int unsigned CellN = GRID_W * GRID_H;
`ifdef SNAKE_FOOD_BLINK_EN
    localparam logic BlinkEn = 1'b1;
`else
    localparam logic BlinkEn = 1'b0;
`endif

    logic [CellN-1:0]  body_q, src_body;
    logic [3:0]        head_x_q, head_y_q, food_x_q, food_y_q;
    logic [3:0]        src_hx, src_hy, src_fx, src_fy;
    logic              coll_q, src_coll;
    logic              xfer, scan_nxt, phase_nxt;
    logic [3:0]        row_nxt;
    logic [GRID_W-1:0] row_bits, head_col, food_col;
    logic [GRID_H-1:0] row_sel_d;
    logic [GRID_W-1:0] body_d, head_d, food_d;

    snake_scan_timer #(
        .GRID_H      (GRID_H),
        .DWELL_CYCLES(DWELL_CYCLES),
        .BLANK_CYCLES(BLANK_CYCLES),
        .FLASH_FRAMES(FLASH_FRAMES)
    ) u_timer (
        .Game_Clk     (Game_Clk),
        .i_Rst_L      (i_Rst_L),
        .o_Scan_Nxt   (scan_nxt),
        .o_Row_Nxt    (row_nxt),
        .o_Phase_Nxt  (phase_nxt),
        .o_Frame_Ready(o_Frame_Ready)
    );

    assign xfer = i_Frame_Valid && o_Frame_Ready;

    // A transfer lands on the same edge as row 0, so render straight from the inputs then.
    always_comb begin
        src_body = xfer ? i_SnakeBody : body_q;
        src_hx   = xfer ? i_Head_X    : head_x_q;
        src_hy   = xfer ? i_Head_Y    : head_y_q;
        src_fx   = xfer ? i_Food_X    : food_x_q;
        src_fy   = xfer ? i_Food_Y    : food_y_q;
        src_coll = xfer ? i_Collision : coll_q;

        row_bits = GRID_W'(src_body >> cell_index(4'd0, row_nxt, GRID_W));
        head_col = (in_grid(src_hx, src_hy, GRID_W, GRID_H) && (src_hy == row_nxt)) ?
                   (GRID_W'(1) << src_hx) : '0;
        food_col = (in_grid(src_fx, src_fy, GRID_W, GRID_H) && (src_fy == row_nxt)) ?
                   (GRID_W'(1) << src_fx) : '0;

        row_sel_d = '0;
        body_d    = '0;
        head_d    = '0;
        food_d    = '0;
        if (scan_nxt) begin
            row_sel_d = GRID_H'(1) << row_nxt;
            body_d    = row_bits & ~head_col;
            head_d    = head_col;
            food_d    = food_col;
            if (src_coll && phase_nxt) begin
                head_d = '1;
                body_d = '0;
                food_d = '0;
            end
            if (BlinkEn && phase_nxt) begin
                food_d = '0;
            end
        end
    end

    always_ff @(posedge Game_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            body_q     <= '0;
            head_x_q   <= '0;
            head_y_q   <= '0;
            food_x_q   <= '0;
            food_y_q   <= '0;
            coll_q     <= 1'b0;
            o_Row_Sel  <= '0;
            o_Col_Body <= '0;
            o_Col_Head <= '0;
            o_Col_Food <= '0;
        end else begin
            body_q     <= src_body;
            head_x_q   <= src_hx;
            head_y_q   <= src_hy;
            food_x_q   <= src_fx;
            food_y_q   <= src_fy;
            coll_q     <= src_coll;
            o_Row_Sel  <= row_sel_d;
            o_Col_Body <= body_d;
            o_Col_Head <= head_d;
            o_Col_Food <= food_d;
        end
    end

endmodule

// File: tb/tb_snake_matrix_scanner.sv
// Self-checking bench for snake_matrix_scanner: table vectors, random snapshots vs a
// timeline-based reference model, collision flash and asynchronous mid-frame reset.
module tb_snake_matrix_scanner;

    localparam int W  = 9;
    localparam int H  = 10;
    localparam int DW = 4;
    localparam int BL = 2;
    localparam int FF = 2;
    localparam int RP = DW + BL;
    localparam int FP = RP * H;

    typedef struct packed {
        logic [W*H-1:0] body;
        logic [3:0]     hx;
        logic [3:0]     hy;
        logic [3:0]     fx;
        logic [3:0]     fy;
        logic           coll;
    } snap_t;

    typedef struct {
        snap_t      s;
        int         row;
        logic [8:0] eb;
        logic [8:0] eh;
        logic [8:0] ef;
    } vec_t;

    logic           Game_Clk = 1'b0;
    logic           i_Rst_L;
    logic           i_Frame_Valid;
    logic           o_Frame_Ready;
    logic [W*H-1:0] i_SnakeBody;
    logic [3:0]     i_Head_X, i_Head_Y, i_Food_X, i_Food_Y;
    logic           i_Collision;
    logic [H-1:0]   o_Row_Sel;
    logic [W-1:0]   o_Col_Body, o_Col_Head, o_Col_Food;

    snap_t drv;
    snap_t msnap;
    int    k;
    int    total;
    int    bad;
    logic  exp_rdy;
    logic  last_xfer;
    vec_t  tbl[6];

    assign i_SnakeBody = drv.body;
    assign i_Head_X    = drv.hx;
    assign i_Head_Y    = drv.hy;
    assign i_Food_X    = drv.fx;
    assign i_Food_Y    = drv.fy;
    assign i_Collision = drv.coll;

    always #5 Game_Clk = ~Game_Clk;

    snake_matrix_scanner #(
        .GRID_W      (W),
        .GRID_H      (H),
        .DWELL_CYCLES(DW),
        .BLANK_CYCLES(BL),
        .FLASH_FRAMES(FF)
    ) dut (
        .Game_Clk     (Game_Clk),
        .i_Rst_L      (i_Rst_L),
        .i_Frame_Valid(i_Frame_Valid),
        .o_Frame_Ready(o_Frame_Ready),
        .i_SnakeBody  (i_SnakeBody),
        .i_Head_X     (i_Head_X),
        .i_Head_Y     (i_Head_Y),
        .i_Food_X     (i_Food_X),
        .i_Food_Y     (i_Food_Y),
        .i_Collision  (i_Collision),
        .o_Row_Sel    (o_Row_Sel),
        .o_Col_Body   (o_Col_Body),
        .o_Col_Head   (o_Col_Head),
        .o_Col_Food   (o_Col_Food)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            if (bad <= 30)
                $display("FAIL %s k=%0d got=%0h want=%0h", nm, k, act, exp_v);
        end
    endtask

    // Expected outputs from position on the timeline: a leading reset blank, then frames of
    // H rows, each row DW driven cycles followed by BL dark cycles.
    task automatic model_out(output logic [H-1:0] rs, output logic [W-1:0] b,
                             output logic [W-1:0] h, output logic [W-1:0] f,
                             output logic rdy);
        int q, r, w, fr;
        logic odd;
        rs = '0; b = '0; h = '0; f = '0; rdy = 1'b0;
        q = k - BL;
        if (q >= 0) begin
            fr  = q / FP;
            r   = (q % FP) / RP;
            w   = q % RP;
            rdy = ((q % FP) == FP - 1);
            odd = ((fr % (2 * FF)) >= FF);
            if (w < DW) begin
                rs[r] = 1'b1;
                for (int x = 0; x < W; x++) begin
                    logic hb, fb;
                    hb   = (int'(msnap.hx) == x) && (int'(msnap.hy) == r);
                    fb   = (int'(msnap.fx) == x) && (int'(msnap.fy) == r);
                    h[x] = hb;
                    f[x] = fb;
                    b[x] = msnap.body[r * W + x] && !hb;
                end
                if (msnap.coll && odd) begin
                    h = '1; b = '0; f = '0;
                end
`ifdef SNAKE_FOOD_BLINK_EN
                if (odd) f = '0;
`endif
            end
        end
    endtask

    task automatic compare_all();
        logic [H-1:0] ers;
        logic [W-1:0] eb, eh, ef;
        logic         er;
        model_out(ers, eb, eh, ef, er);
        chk("row_sel", 128'(o_Row_Sel), 128'(ers));
        chk("col_body", 128'(o_Col_Body), 128'(eb));
        chk("col_head", 128'(o_Col_Head), 128'(eh));
        chk("col_food", 128'(o_Col_Food), 128'(ef));
        chk("ready", 128'(o_Frame_Ready), 128'(er));
        exp_rdy = er;
    endtask

    task automatic step();
        last_xfer = exp_rdy && i_Frame_Valid;
        @(posedge Game_Clk);
        if (last_xfer) msnap = drv;
        k++;
        #1;
        compare_all();
    endtask

    task automatic release_rst();
        @(negedge Game_Clk);
        i_Rst_L = 1'b1;
        k       = 0;
        msnap   = '0;
        exp_rdy = 1'b0;
        compare_all();
    endtask

    task automatic load_snap(input snap_t s);
        logic done;
        done          = 1'b0;
        drv           = s;
        i_Frame_Valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            step();
            done = last_xfer;
        end
        i_Frame_Valid = 1'b0;
        chk("load_xfer", 128'(done), 128'(1));
    endtask

    task automatic goto_row(input int r);
        for (int i = 0; i < FP && ((k - BL) % FP) != r * RP; i++) step();
    endtask

    function automatic snap_t rand_snap();
        snap_t      s;
        logic [95:0] rv;
        rv     = {$urandom, $urandom, $urandom};
        s.body = rv[W*H-1:0];
        s.hx   = 4'($urandom_range(0, 15));
        s.hy   = 4'($urandom_range(0, 15));
        s.fx   = 4'($urandom_range(0, 15));
        s.fy   = 4'($urandom_range(0, 15));
        s.coll = ($urandom_range(0, 3) == 0);
        return s;
    endfunction

    initial begin
        int    rdy_cnt;
        snap_t cs;
        total = 0;
        bad   = 0;

        tbl[0] = '{s: '{body: 90'h203, hx: 4'd1, hy: 4'd0, fx: 4'd3, fy: 4'd4, coll: 1'b0},
                   row: 0, eb: 9'b000000001, eh: 9'b000000010, ef: 9'b000000000};
        tbl[1] = '{s: '{body: 90'h203, hx: 4'd1, hy: 4'd0, fx: 4'd3, fy: 4'd4, coll: 1'b0},
                   row: 1, eb: 9'b000000001, eh: 9'b000000000, ef: 9'b000000000};
        tbl[2] = '{s: '{body: 90'h203, hx: 4'd1, hy: 4'd0, fx: 4'd3, fy: 4'd4, coll: 1'b0},
                   row: 4, eb: 9'b000000000, eh: 9'b000000000, ef: 9'b000001000};
        tbl[3] = '{s: '{body: 90'h3 << 88, hx: 4'd8, hy: 4'd9, fx: 4'd8, fy: 4'd9, coll: 1'b0},
                   row: 9, eb: 9'b010000000, eh: 9'b100000000, ef: 9'b100000000};
        tbl[4] = '{s: '{body: 90'h1FF, hx: 4'd9, hy: 4'd0, fx: 4'd0, fy: 4'd10, coll: 1'b0},
                   row: 0, eb: 9'b111111111, eh: 9'b000000000, ef: 9'b000000000};
        tbl[5] = '{s: '{body: 90'h1FF << 81, hx: 4'd2, hy: 4'd10, fx: 4'd9, fy: 4'd9, coll: 1'b0},
                   row: 9, eb: 9'b111111111, eh: 9'b000000000, ef: 9'b000000000};

        i_Rst_L       = 1'b0;
        i_Frame_Valid = 1'b0;
        drv           = '0;
        msnap         = '0;
        exp_rdy       = 1'b0;
        k             = 0;
        repeat (3) @(posedge Game_Clk);
        release_rst();

        // Idle scan with empty snapshot
        for (int i = 0; i < FP + 10; i++) step();

        // Table vectors
        for (int v = 0; v < 6; v++) begin
            load_snap(tbl[v].s);
            goto_row(tbl[v].row);
            chk($sformatf("tbl%0d_body", v), 128'(o_Col_Body), 128'(tbl[v].eb));
            chk($sformatf("tbl%0d_head", v), 128'(o_Col_Head), 128'(tbl[v].eh));
            chk($sformatf("tbl%0d_food", v), 128'(o_Col_Food), 128'(tbl[v].ef));
            chk($sformatf("tbl%0d_rowsel", v), 128'(o_Row_Sel), 128'(1) << tbl[v].row);
        end

        // Random snapshots with random valid
        for (int i = 0; i < 400; i++) begin
            drv           = rand_snap();
            i_Frame_Valid = $urandom_range(0, 1) == 1;
            step();
        end

        // Valid held high with a fresh snapshot every cycle: exactly one accept per frame
        rdy_cnt       = 0;
        i_Frame_Valid = 1'b1;
        for (int i = 0; i < 3 * FP; i++) begin
            drv = rand_snap();
            step();
            if (o_Frame_Ready) rdy_cnt++;
        end
        i_Frame_Valid = 1'b0;
        chk("ready_pulses", 128'(rdy_cnt), 128'(3));

        // Collision flash
        cs      = rand_snap();
        cs.coll = 1'b1;
        cs.hx   = 4'd4;
        cs.hy   = 4'd4;
        load_snap(cs);
        for (int i = 0; i < 5 * FP &&
             !((((k - BL) / FP) % (2 * FF)) == FF && ((k - BL) % FP) == 5 * RP); i++) step();
        chk("flash_head", 128'(o_Col_Head), 128'(9'h1FF));
        chk("flash_body", 128'(o_Col_Body), 128'(0));
        chk("flash_rowsel", 128'(o_Row_Sel), 128'(10'b0000100000));
        for (int i = 0; i < 3 * FP; i++) step();

        // Asynchronous reset in the middle of row 0
        goto_row(0);
        step();
        #1;
        i_Rst_L = 1'b0;
        #1;
        chk("async_rst_rowsel", 128'(o_Row_Sel), 128'(0));
        chk("async_rst_head", 128'(o_Col_Head), 128'(0));
        chk("async_rst_ready", 128'(o_Frame_Ready), 128'(0));
        release_rst();
        for (int i = 0; i < 2 * FP; i++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
